fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write-side arbiter that shares one FIFO write port between N_REQ producers. Each producer presents data with a valid/ready handshake; the arbiter grants one producer at a time for a bounded burst. It drives the FIFO's `data_in`/`wr_en` through one register stage and throttles on `full`/`almostfull` so the FIFO never overflows.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- FIFO_WIDTH, 16, data width
- BURST, 4, max beats per grant (1..15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  requester i has data
- req_data  in  N_REQ*FIFO_WIDTH  requester i data at bits [i*FIFO_WIDTH +: FIFO_WIDTH]
- req_ready  out  N_REQ  combinational; beat accepted when req_valid[i] & req_ready[i]
- data_in  out  FIFO_WIDTH  registered write data to FIFO
- wr_en  out  1  registered write enable to FIFO
- full  in  1  FIFO full
- almostfull  in  1  FIFO has exactly one free slot
- grant_valid  out  1  a requester currently holds the grant
- grant_id  out  $clog2(N_REQ)  index of granted requester
- ovf_err  out  1  one-cycle pulse when wr_en & full (must never fire)

## Operation
- States: IDLE, GRANT.
- IDLE: if any req_valid, grant the first valid index at or after `ptr` (cyclic search); grant_id <= that index, grant_valid <= 1, beat_cnt <= 0, go GRANT. Otherwise stay.
- GRANT: stall = full | (wr_en & almostfull). req_ready[grant_id] = ~stall; all other req_ready = 0. req_ready is 0 for every bit in IDLE.
- Transfer (valid & ready on granted index): next edge wr_en <= 1, data_in <= granted slice, beat_cnt++. No transfer: wr_en <= 0, data_in holds.
- Release (-> IDLE, grant_valid <= 0, ptr <= grant_id+1 mod N_REQ) when: transfer makes beat_cnt reach BURST; or granted req_valid is low while stall is low.
- Stall never releases the grant; beats wait.
- ovf_err <= wr_en & full, registered, one pulse per offending cycle.
- Reset mid-burst: all state cleared immediately; a pending registered write is dropped (wr_en forced 0).

## Timing
- Reset values: wr_en 0, data_in 0, grant_valid 0, grant_id 0, ovf_err 0, ptr 0, beat_cnt 0, state IDLE.
- Arbitration latency: req_valid rising in IDLE -> grant_valid and first possible req_ready next cycle.
- Write latency: accepted beat at edge t appears on wr_en/data_in during cycle t+1.
- Throughput: 1 beat/cycle within a grant; one IDLE bubble cycle between grants.
- Full look-ahead: with one free slot and a write in flight, no further beat is accepted; guarantees zero overflow with the one-cycle write register.
- Wrap: ptr wraps N_REQ-1 -> 0; beat_cnt width $clog2(BURST+1).

## Configuration
- FIFO_ARB_EARLY_THROTTLE_EN defined: stall = full | almostfull (stop one slot early, simpler timing, last FIFO slot unused by this arbiter).
- Undefined: stall = full | (wr_en & almostfull) as above (full FIFO utilisation).

## Test plan
- Reset: assert rst_n=0 mid-burst with wr_en=1 -> all outputs 0 in same cycle, state IDLE, ptr 0.
- Round robin: all four req_valid=1 continuously, BURST=4 -> grant_id sequence 0,1,2,3,0, four wr_en beats each, one idle cycle between grants, data order matches per-requester order.
- Early release: only req 2 valid for 2 beats then drops -> 2 writes, release, next grant from ptr=3 (req 3 if valid, else wrap to 0).
- Full throttle: FIFO depth 8, no reads, req 0 streaming -> exactly 8 writes, req_ready stays 0 afterward, ovf_err never 1; one read frees a slot -> exactly one more write.
- Almost-full look-ahead: almostfull=1 with wr_en=1 -> req_ready=0 that cycle; with FIFO_ARB_EARLY_THROTTLE_EN, req_ready=0 whenever almostfull=1.
- Single requester BURST=1: req 1 valid constantly -> write every other cycle (grant, bubble), grant_id always 1.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer request bus and FIFO write port shared by fifo_wr_arbiter and its environment.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int FIFO_WIDTH = 16
);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ*FIFO_WIDTH-1:0] req_data;
  logic [N_REQ-1:0] req_ready;
  logic [FIFO_WIDTH-1:0] data_in;
  logic wr_en;
  logic full;
  logic almostfull;
  logic grant_valid;
  logic [$clog2(N_REQ)-1:0] grant_id;
  logic ovf_err;
  modport master(
    output req_valid, req_data, full, almostfull,
    input req_ready, data_in, wr_en, grant_valid, grant_id, ovf_err
  );
  modport slave(
    input req_valid, req_data, full, almostfull,
    output req_ready, data_in, wr_en, grant_valid, grant_id, ovf_err
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one registered FIFO write port between N_REQ producers.
// Define FIFO_ARB_EARLY_THROTTLE_EN to stall on almostfull alone (last FIFO slot left unused).
module fifo_wr_arbiter #(
  parameter int N_REQ = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int BURST = 4
) (
  input logic clk,
  input logic rst_n,
  fifo_wr_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(BURST + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nx;
  logic [IW-1:0] ptr, ptr_nx, gid, gid_nx, pick;
  logic [IW:0] idx;
  logic [CW-1:0] cnt, cnt_nx;
  logic stall, xfer, wr_en, ovf_err;
  logic [FIFO_WIDTH-1:0] data_in;
`ifdef FIFO_ARB_EARLY_THROTTLE_EN
  assign stall = bus.full | bus.almostfull;
`else
  // a write already in the output register will consume the last free slot
  assign stall = bus.full | (wr_en & bus.almostfull);
`endif
  assign xfer = state == GRANT && !stall && bus.req_valid[gid];
  assign bus.req_ready = (state == GRANT && !stall) ? (N_REQ)'(1) << gid : '0;
  assign bus.wr_en = wr_en;
  assign bus.data_in = data_in;
  assign bus.ovf_err = ovf_err;
  assign bus.grant_valid = state == GRANT;
  assign bus.grant_id = gid;
  // descending scan so the first valid index at or after ptr wins
  always_comb begin
    pick = ptr;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (IW + 1)'(k);
      idx = idx >= (IW + 1)'(N_REQ) ? idx - (IW + 1)'(N_REQ) : idx;
      if (bus.req_valid[idx[IW-1:0]]) pick = idx[IW-1:0];
    end
  end
  always_comb begin
    state_nx = state;
    gid_nx = gid;
    cnt_nx = cnt;
    ptr_nx = ptr;
    if (state == IDLE) begin
      if (|bus.req_valid) begin
        state_nx = GRANT;
        gid_nx = pick;
        cnt_nx = '0;
      end
    end else begin
      cnt_nx = xfer ? cnt + 1'b1 : cnt;
      if ((xfer && cnt_nx == CW'(BURST)) || (!bus.req_valid[gid] && !stall)) begin
        state_nx = IDLE;
        ptr_nx = gid == IW'(N_REQ - 1) ? '0 : gid + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      gid <= '0;
      cnt <= '0;
      wr_en <= 1'b0;
      data_in <= '0;
      ovf_err <= 1'b0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      gid <= gid_nx;
      cnt <= cnt_nx;
      wr_en <= xfer;
      ovf_err <= wr_en & bus.full;
      if (xfer) data_in <= bus.req_data[gid*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end
endmodule
